// File: rtl/write_burst_buffer.sv
// Single-line CPU write-combining buffer: merges 16-bit writes into one 4-word line
// and flushes it to the SDRAM controller as a 4-beat burst with per-byte masks.
module write_burst_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_rw,
    input  logic [31:0] i_cpu_addr,
    input  logic [15:0] i_cpu_data,
    input  logic [1:0]  i_cpu_be,
    output logic        o_cpu_ack,
    output logic        o_wb_dirty,
    output logic        o_wb_hit,
    output logic        o_sdram_req,
    output logic [31:0] o_sdram_addr,
    input  logic        i_sdram_burst,
    output logic [15:0] o_sdram_data,
    output logic [1:0]  o_sdram_dqm
);

    typedef enum logic [0:0] {StIdle, StBurst} state_t;

    state_t      r_state;
    logic [15:0] r_word [4];
    logic [7:0]  r_mask;
    logic [28:0] r_line;
    logic [1:0]  r_idx;
    logic        r_release;
    logic        r_dirty;
    logic        r_sdram_req;
    logic        r_cpu_ack;

    logic        w_line_match;
    logic        w_accept;
    logic [1:0]  w_widx;
    logic        w_unused;

    assign w_line_match = (i_cpu_addr[31:3] == r_line);
    assign w_widx       = i_cpu_addr[2:1];
    assign w_unused     = i_cpu_addr[0];

    // A pending burst always wins over a CPU write in the same cycle.
    assign w_accept = (r_state == StIdle) && i_cpu_req && !i_cpu_rw && !r_release &&
                      !i_sdram_burst && (!r_dirty || w_line_match);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_mask      <= 8'hFF;
            r_idx       <= 2'd0;
            r_release   <= 1'b0;
            r_dirty     <= 1'b0;
            r_sdram_req <= 1'b0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_cpu_ack <= w_accept;
            // Blocks a held request from being accepted a second time.
            if (w_accept) begin
                r_release <= 1'b1;
            end else if (!i_cpu_req) begin
                r_release <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (r_dirty && i_sdram_burst) begin
                        r_sdram_req <= 1'b0;
                        r_idx       <= 2'd1;
                        r_state     <= StBurst;
                    end else if (w_accept) begin
                        r_line <= i_cpu_addr[31:3];
                        if (i_cpu_be[0]) begin
                            r_word[w_widx][7:0]    <= i_cpu_data[7:0];
                            r_mask[{w_widx, 1'b0}] <= 1'b0;
                        end
                        if (i_cpu_be[1]) begin
                            r_word[w_widx][15:8]   <= i_cpu_data[15:8];
                            r_mask[{w_widx, 1'b1}] <= 1'b0;
                        end
                        r_dirty     <= 1'b1;
                        r_sdram_req <= 1'b1;
                    end
                end
                StBurst: begin
                    if (i_sdram_burst) begin
                        r_idx <= r_idx + 2'd1;
                    end else begin
                        r_dirty <= 1'b0;
                        r_mask  <= 8'hFF;
                        r_idx   <= 2'd0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cpu_ack    = r_cpu_ack;
    assign o_wb_dirty   = r_dirty;
    assign o_wb_hit     = r_dirty && w_line_match;
    assign o_sdram_req  = r_sdram_req;
    assign o_sdram_addr = {r_line, 3'b000};
    assign o_sdram_data = r_word[r_idx];
    assign o_sdram_dqm  = r_mask[{r_idx, 1'b0} +: 2];

endmodule

// File: tb/tb_write_burst_buffer.sv
// Bench for write_burst_buffer: directed scenarios followed by randomized CPU/SDRAM
// traffic, every cycle compared against a byte-level reference model.
module tb_write_burst_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rw, sdram_burst;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_data;
    logic [1:0]  cpu_be;
    logic        cpu_ack, wb_dirty, wb_hit, sdram_req;
    logic [31:0] sdram_addr;
    logic [15:0] sdram_data;
    logic [1:0]  sdram_dqm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    write_burst_buffer u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_cpu_req    (cpu_req),
        .i_cpu_rw     (cpu_rw),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_data   (cpu_data),
        .i_cpu_be     (cpu_be),
        .o_cpu_ack    (cpu_ack),
        .o_wb_dirty   (wb_dirty),
        .o_wb_hit     (wb_hit),
        .o_sdram_req  (sdram_req),
        .o_sdram_addr (sdram_addr),
        .i_sdram_burst(sdram_burst),
        .o_sdram_data (sdram_data),
        .o_sdram_dqm  (sdram_dqm)
    );

    // Reference model: line as 8 bytes with a written flag per byte.
    logic [7:0]  m_byte [8];
    bit          m_wr   [8];
    logic [28:0] m_line = '0;
    bit          m_dirty, m_req, m_ack, m_rel, m_flush;
    int          m_beat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
        m_flush = 1'b0;
        m_beat  = 0;
        m_dirty = 1'b0;
    endtask

    task automatic model_update();
        bit acc;
        int w;
        acc = 1'b0;
        if (!reset) begin
            model_clear();
            m_req = 1'b0;
            m_ack = 1'b0;
            m_rel = 1'b0;
            for (int i = 0; i < 8; i++) m_byte[i] = 8'h00;
            return;
        end
        if (!m_flush) begin
            if (sdram_burst && m_dirty) begin
                m_req   = 1'b0;
                m_flush = 1'b1;
                m_beat  = 1;
            end else if (cpu_req && !cpu_rw && !m_rel && !sdram_burst &&
                         (!m_dirty || cpu_addr[31:3] == m_line)) begin
                acc = 1'b1;
            end
        end else if (sdram_burst) begin
            m_beat = (m_beat + 1) % 4;
        end else begin
            model_clear();
        end
        if (acc) begin
            w      = int'(cpu_addr[2:1]);
            m_line = cpu_addr[31:3];
            if (cpu_be[0]) begin m_byte[2*w]   = cpu_data[7:0];  m_wr[2*w]   = 1'b1; end
            if (cpu_be[1]) begin m_byte[2*w+1] = cpu_data[15:8]; m_wr[2*w+1] = 1'b1; end
            m_dirty = 1'b1;
            m_req   = 1'b1;
            m_rel   = 1'b1;
        end else if (!cpu_req) begin
            m_rel = 1'b0;
        end
        m_ack = acc;
    endtask

    task automatic check_outputs();
        int          b;
        logic [15:0] em, ed;
        b  = m_flush ? m_beat : 0;
        em = {{8{m_wr[2*b+1]}}, {8{m_wr[2*b]}}};
        ed = {m_byte[2*b+1], m_byte[2*b]};
        chk("cpu_ack", 32'(cpu_ack), 32'(m_ack));
        chk("wb_dirty", 32'(wb_dirty), 32'(m_dirty));
        chk("sdram_req", 32'(sdram_req), 32'(m_req));
        chk("wb_hit", 32'(wb_hit), 32'(m_dirty && cpu_addr[31:3] == m_line));
        chk("sdram_dqm", 32'(sdram_dqm), 32'({!m_wr[2*b+1], !m_wr[2*b]}));
        chk("sdram_data", 32'(sdram_data & em), 32'(ed & em));
        if (m_dirty) chk("sdram_addr", sdram_addr, {m_line, 3'b000});
    endtask

    // Called at the falling edge with inputs already driven.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be);
        cpu_req  = 1'b1;
        cpu_rw   = 1'b0;
        cpu_addr = a;
        cpu_data = d;
        cpu_be   = be;
        for (int i = 0; i < 20 && !cpu_ack; i++) step();
        chk("write_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        step();
    endtask

    task automatic burst4();
        sdram_burst = 1'b1;
        repeat (4) step();
        sdram_burst = 1'b0;
        step();
    endtask

    logic [15:0] exp_d [4];
    logic [1:0]  exp_m [4];
    int          cnt, ctl_cnt, post_cnt, read_len;
    bit          acked;

    initial begin
        reset       = 1'b0;
        cpu_req     = 1'b0;
        cpu_rw      = 1'b0;
        cpu_addr    = 32'h0;
        cpu_data    = 16'h0;
        cpu_be      = 2'b00;
        sdram_burst = 1'b0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        step();
        reset = 1'b1;
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dirty", 32'(wb_dirty), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_dqm", 32'(sdram_dqm), 32'd3);

        // First write: ack, req and address one cycle later.
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        cpu_data = 16'h1234;
        cpu_be   = 2'b11;
        step();
        chk("w1_ack", 32'(cpu_ack), 32'd1);
        chk("w1_req", 32'(sdram_req), 32'd1);
        chk("w1_addr", sdram_addr, 32'h100);
        chk("w1_dirty", 32'(wb_dirty), 32'd1);
        cpu_req = 1'b0;
        step();
        chk("w1_ack_pulse", 32'(cpu_ack), 32'd0);

        cpu_write(32'h100, 16'hFF56, 2'b01);
        cpu_write(32'h106, 16'hDDDD, 2'b11);
        cpu_addr = 32'h104;
        #1 chk("hit_104", 32'(wb_hit), 32'd1);
        cpu_addr = 32'h204;
        #1 chk("hit_204", 32'(wb_hit), 32'd0);

        exp_d = '{16'h1256, 16'h0, 16'h0, 16'hDDDD};
        exp_m = '{2'b00, 2'b11, 2'b11, 2'b00};
        sdram_burst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("burst_dqm", 32'(sdram_dqm), 32'(exp_m[k]));
            if (exp_m[k] == 2'b00) chk("burst_data", 32'(sdram_data), 32'(exp_d[k]));
            step();
        end
        sdram_burst = 1'b0;
        step();
        chk("flush_dirty", 32'(wb_dirty), 32'd0);
        chk("flush_dqm", 32'(sdram_dqm), 32'd3);

        // Different line while dirty stalls until the flush completes.
        cpu_write(32'h100, 16'hAAAA, 2'b11);
        cpu_req  = 1'b1;
        cpu_addr = 32'h200;
        cpu_data = 16'h5555;
        repeat (3) begin
            step();
            chk("stall_ack", 32'(cpu_ack), 32'd0);
        end
        sdram_burst = 1'b1;
        repeat (4) step();
        sdram_burst = 1'b0;
        for (int i = 0; i < 10 && !cpu_ack; i++) step();
        chk("stall_ack_late", 32'(cpu_ack), 32'd1);
        chk("stall_addr", sdram_addr, 32'h200);
        cpu_req = 1'b0;
        step();
        burst4();

        // Held request yields exactly one ack.
        cnt      = 0;
        cpu_req  = 1'b1;
        cpu_addr = 32'h300;
        cpu_data = 16'hBEEF;
        cpu_be   = 2'b10;
        repeat (11) begin
            step();
            cnt += int'(cpu_ack);
        end
        chk("held_acks", 32'(cnt), 32'd1);
        cpu_req = 1'b0;
        step();

        // Reset on burst beat 2 discards the line.
        sdram_burst = 1'b1;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_dirty", 32'(wb_dirty), 32'd0);
        chk("mid_rst_req", 32'(sdram_req), 32'd0);
        chk("mid_rst_dqm", 32'(sdram_dqm), 32'd3);
        repeat (2) step();
        sdram_burst = 1'b0;
        step();

        ctl_cnt  = 0;
        post_cnt = 0;
        read_len = 0;
        acked    = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (ctl_cnt > 0) begin
                sdram_burst = 1'b1;
                ctl_cnt--;
            end else if (!sdram_burst && m_req && $urandom_range(0, 2) == 0) begin
                sdram_burst = 1'b1;
                ctl_cnt     = 3;
            end else if (!sdram_burst && !m_dirty && $urandom_range(0, 49) == 0) begin
                sdram_burst = 1'b1;
                ctl_cnt     = 3;
            end else begin
                sdram_burst = 1'b0;
            end
            if (cpu_req) begin
                if (!cpu_rw && (acked || cpu_ack)) begin
                    acked = 1'b1;
                    if (post_cnt == 0) cpu_req = 1'b0;
                    else post_cnt--;
                end else if (cpu_rw) begin
                    if (read_len == 0) cpu_req = 1'b0;
                    else read_len--;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                cpu_req  = 1'b1;
                cpu_rw   = ($urandom_range(0, 4) == 0);
                cpu_addr = 32'h100 * $urandom_range(1, 3) + 32'($urandom_range(0, 7));
                cpu_data = 16'($urandom);
                cpu_be   = 2'($urandom);
                acked    = 1'b0;
                post_cnt = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 2);
                read_len = $urandom_range(0, 3);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
